// File: rtl/sparc_exu_alu_pipe.sv
// Pipelined integer ALU: add/sub/logic/move results with icc/xcc condition codes and VA-hole check.
// LAT=1 registers everything at the output; LAT=2 adds an operand/adder stage ahead of the CC stage.
module sparc_exu_alu_pipe #(
    parameter int DATA_W = 64,
    parameter int VA_W   = 48,
    parameter int LAT    = 1
) (
    input  logic              rclk,
    input  logic              rst_l,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [2:0]        in_op,
    input  logic              in_inv,
    input  logic              in_cin,
    input  logic              in_casa,
    input  logic [DATA_W-1:0] in_rs1,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_rs3,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [VA_W-1:0]   out_va,
    output logic              out_va_inv,
    output logic [3:0]        out_icc,
    output logic [3:0]        out_xcc
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_MOV   = 3'd5,
        OP_PASS  = 3'd6,
        OP_SETHI = 3'd7
    } op_e;

    localparam int PK_W = 2 * DATA_W + 4;

    op_e               w_op;
    logic              w_adv;
    logic              w_isSub;
    logic              w_isArith;
    logic              w_cinEff;
    logic [DATA_W-1:0] w_rs2Add;
    logic [DATA_W-1:0] w_rs2Log;
    logic [DATA_W:0]   w_sumX;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W-1:0] w_vaSel;
    logic              w_carry31In;
    logic              w_carry32;
    logic              w_c32;
    logic              w_c64;
    logic              w_v32;
    logic              w_v64;
    logic [PK_W-1:0]   w_aPk;

    assign w_op      = op_e'(in_op);
    assign w_adv     = in_rdy;
    assign in_rdy    = out_rdy | ~out_vld;
    assign w_isSub   = (w_op == OP_SUB);
    assign w_isArith = (w_op == OP_ADD) | w_isSub;
    assign w_rs2Add  = w_isSub ? ~in_rs2 : in_rs2;
    assign w_rs2Log  = in_inv ? ~in_rs2 : in_rs2;
    assign w_cinEff  = w_isSub | ((w_op == OP_ADD) & in_cin);

    assign w_sumX = {1'b0, in_rs1} + {1'b0, w_rs2Add} + {{DATA_W{1'b0}}, w_cinEff};
    assign w_sum  = w_sumX[DATA_W-1:0];

    // The icc carry is rebuilt from bit 31 of the full-width adder so no second adder is needed.
    assign w_carry31In = in_rs1[31] ^ w_rs2Add[31] ^ w_sum[31];
    assign w_carry32   = (in_rs1[31] & w_rs2Add[31]) | (w_carry31In & (in_rs1[31] | w_rs2Add[31]));
    assign w_c32       = w_isArith & (w_carry32 ^ w_isSub);
    assign w_c64       = w_isArith & (w_sumX[DATA_W] ^ w_isSub);
    assign w_v32       = w_isArith & (in_rs1[31] == w_rs2Add[31]) & (w_sum[31] != in_rs1[31]);
    assign w_v64       = w_isArith & (in_rs1[DATA_W-1] == w_rs2Add[DATA_W-1])
                                   & (w_sum[DATA_W-1] != in_rs1[DATA_W-1]);

    always_comb begin
        w_res = w_sum;
        case (w_op)
            OP_AND:   w_res = in_rs1 & w_rs2Log;
            OP_OR:    w_res = in_rs1 | w_rs2Log;
            OP_XOR:   w_res = in_rs1 ^ w_rs2Log;
            OP_MOV:   w_res = in_rs2;
            OP_PASS:  w_res = in_rs3;
            OP_SETHI: begin
                w_res         = '0;
                w_res[31:10]  = in_rs2[31:10];
            end
            default:  w_res = w_sum;
        endcase
    end

    assign w_vaSel = in_casa ? in_rs1 : w_sum;
    assign w_aPk   = {w_res, w_vaSel, w_v32, w_c32, w_v64, w_c64};

    logic              w_bVld;
    logic [PK_W-1:0]   w_bPk;

    generate
        if (LAT == 2) begin : g_lat2
            logic            r_s1Vld;
            logic [PK_W-1:0] r_s1Pk;

            always_ff @(posedge rclk) begin
                if (!rst_l) begin
                    r_s1Vld <= 1'b0;
                    r_s1Pk  <= '0;
                end else if (w_adv) begin
                    r_s1Vld <= in_vld;
                    if (in_vld) begin
                        r_s1Pk <= w_aPk;
                    end
                end
            end

            assign w_bVld = r_s1Vld;
            assign w_bPk  = r_s1Pk;
        end else begin : g_lat1
            assign w_bVld = in_vld;
            assign w_bPk  = w_aPk;
        end
    endgenerate

    logic [DATA_W-1:0]        w_bRes;
    logic [DATA_W-1:0]        w_bVa;
    logic                     w_bV32;
    logic                     w_bC32;
    logic                     w_bV64;
    logic                     w_bC64;
    logic [DATA_W-VA_W:0]     w_vaUpper;
    logic [3:0]               w_icc;
    logic [3:0]               w_xcc;
    logic                     w_vaInv;

    assign {w_bRes, w_bVa, w_bV32, w_bC32, w_bV64, w_bC64} = w_bPk;

    assign w_icc     = {w_bRes[31], ~|w_bRes[31:0], w_bV32, w_bC32};
    assign w_xcc     = {w_bRes[DATA_W-1], ~|w_bRes, w_bV64, w_bC64};
    assign w_vaUpper = w_bVa[DATA_W-1:VA_W-1];
    assign w_vaInv   = ~(&w_vaUpper | ~|w_vaUpper);

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_va     <= '0;
            out_va_inv <= 1'b0;
            out_icc    <= '0;
            out_xcc    <= '0;
        end else if (w_adv) begin
            out_vld <= w_bVld;
            if (w_bVld) begin
                out_data   <= w_bRes;
                out_va     <= w_bVa[VA_W-1:0];
                out_va_inv <= w_vaInv;
                out_icc    <= w_icc;
                out_xcc    <= w_xcc;
            end
        end
    end

endmodule

// File: tb/tb_sparc_exu_alu_pipe.sv
// Bench for sparc_exu_alu_pipe: a LAT=1 and a LAT=2 instance share stimulus, each with its own
// out_rdy and its own expected-result queue filled on acceptance and drained on output transfer.
module tb_sparc_exu_alu_pipe;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_MOV   = 3'd5;
    localparam logic [2:0] OP_PASS  = 3'd6;
    localparam logic [2:0] OP_SETHI = 3'd7;

    typedef struct packed {
        logic [63:0] data;
        logic [47:0] va;
        logic        vaInv;
        logic [3:0]  icc;
        logic [3:0]  xcc;
    } exp_t;

    logic        rclk   = 1'b0;
    logic        rst_l  = 1'b0;
    logic        inVld  = 1'b0;
    logic [2:0]  inOp   = '0;
    logic        inInv  = 1'b0;
    logic        inCin  = 1'b0;
    logic        inCasa = 1'b0;
    logic [63:0] inRs1  = '0;
    logic [63:0] inRs2  = '0;
    logic [63:0] inRs3  = '0;
    logic        rdy1   = 1'b1;
    logic        rdy2   = 1'b1;

    logic        inRdy1, inRdy2;
    logic        o1Vld, o2Vld;
    logic [63:0] o1Data, o2Data;
    logic [47:0] o1Va, o2Va;
    logic        o1VaInv, o2VaInv;
    logic [3:0]  o1Icc, o2Icc, o1Xcc, o2Xcc;

    int   nVectors     = 0;
    int   nMiscompares = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t eMon1, eMon2;
    bit   randDone;

    sparc_exu_alu_pipe #(.DATA_W(64), .VA_W(48), .LAT(1)) u_dut1 (
        .rclk(rclk), .rst_l(rst_l), .in_vld(inVld), .in_rdy(inRdy1), .in_op(inOp),
        .in_inv(inInv), .in_cin(inCin), .in_casa(inCasa), .in_rs1(inRs1), .in_rs2(inRs2),
        .in_rs3(inRs3), .out_vld(o1Vld), .out_rdy(rdy1), .out_data(o1Data), .out_va(o1Va),
        .out_va_inv(o1VaInv), .out_icc(o1Icc), .out_xcc(o1Xcc)
    );

    sparc_exu_alu_pipe #(.DATA_W(64), .VA_W(48), .LAT(2)) u_dut2 (
        .rclk(rclk), .rst_l(rst_l), .in_vld(inVld), .in_rdy(inRdy2), .in_op(inOp),
        .in_inv(inInv), .in_cin(inCin), .in_casa(inCasa), .in_rs1(inRs1), .in_rs2(inRs2),
        .in_rs3(inRs3), .out_vld(o2Vld), .out_rdy(rdy2), .out_data(o2Data), .out_va(o2Va),
        .out_va_inv(o2VaInv), .out_icc(o2Icc), .out_xcc(o2Xcc)
    );

    always #5 rclk = ~rclk;

    // Reference model: signed-range overflow and unsigned-compare borrow, independent of gate form.
    function automatic exp_t model(input logic [2:0] op, input logic inv, input logic cin,
                                   input logic casa, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] c);
        exp_t        e;
        logic [64:0] s;
        logic [32:0] s32;
        logic [65:0] w;
        logic [33:0] w32;
        logic [63:0] res, vaFull, bl;
        logic [16:0] up;
        logic        ar, ci, cc32, cc64, vv32, vv64;
        ar = (op == OP_ADD) || (op == OP_SUB);
        bl = inv ? ~b : b;
        if (op == OP_SUB) begin
            s    = {1'b0, a} - {1'b0, b};
            w    = {{2{a[63]}}, a} - {{2{b[63]}}, b};
            w32  = {{2{a[31]}}, a[31:0]} - {{2{b[31]}}, b[31:0]};
            cc64 = (a < b);
            cc32 = (a[31:0] < b[31:0]);
        end else begin
            ci   = (op == OP_ADD) ? cin : 1'b0;
            s    = {1'b0, a} + {1'b0, b} + {64'd0, ci};
            s32  = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, ci};
            w    = {{2{a[63]}}, a} + {{2{b[63]}}, b} + {65'd0, ci};
            w32  = {{2{a[31]}}, a[31:0]} + {{2{b[31]}}, b[31:0]} + {33'd0, ci};
            cc64 = s[64];
            cc32 = s32[32];
        end
        vv64 = (w[64] != w[63]);
        vv32 = (w32[32] != w32[31]);
        case (op)
            OP_AND:   res = a & bl;
            OP_OR:    res = a | bl;
            OP_XOR:   res = a ^ bl;
            OP_MOV:   res = b;
            OP_PASS:  res = c;
            OP_SETHI: res = {32'd0, b[31:10], 10'd0};
            default:  res = s[63:0];
        endcase
        vaFull  = casa ? a : s[63:0];
        up      = vaFull[63:47];
        e.data  = res;
        e.va    = vaFull[47:0];
        e.vaInv = !((up == 17'd0) || (up == 17'h1FFFF));
        e.icc   = {res[31], res[31:0] == 32'd0, ar & vv32, ar & cc32};
        e.xcc   = {res[63], res == 64'd0, ar & vv64, ar & cc64};
        return e;
    endfunction

    // Scoreboard: inputs and outputs are stable at the falling edge, so both queues move there.
    always @(negedge rclk) begin
        if (!rst_l) begin
            q1.delete();
            q2.delete();
        end else begin
            if (o1Vld && rdy1) begin
                nVectors++;
                if (q1.size() == 0) begin
                    nMiscompares++;
                    $display("[TB] FAIL sb_lat1 unexpected output data=%h", o1Data);
                end else begin
                    eMon1 = q1.pop_front();
                    if ({o1Data, o1Va, o1VaInv, o1Icc, o1Xcc} !== eMon1) begin
                        nMiscompares++;
                        $display("[TB] FAIL sb_lat1 got data=%h va=%h inv=%b icc=%b xcc=%b want data=%h va=%h inv=%b icc=%b xcc=%b",
                                 o1Data, o1Va, o1VaInv, o1Icc, o1Xcc,
                                 eMon1.data, eMon1.va, eMon1.vaInv, eMon1.icc, eMon1.xcc);
                    end
                end
            end
            if (o2Vld && rdy2) begin
                nVectors++;
                if (q2.size() == 0) begin
                    nMiscompares++;
                    $display("[TB] FAIL sb_lat2 unexpected output data=%h", o2Data);
                end else begin
                    eMon2 = q2.pop_front();
                    if ({o2Data, o2Va, o2VaInv, o2Icc, o2Xcc} !== eMon2) begin
                        nMiscompares++;
                        $display("[TB] FAIL sb_lat2 got data=%h va=%h inv=%b icc=%b xcc=%b want data=%h va=%h inv=%b icc=%b xcc=%b",
                                 o2Data, o2Va, o2VaInv, o2Icc, o2Xcc,
                                 eMon2.data, eMon2.va, eMon2.vaInv, eMon2.icc, eMon2.xcc);
                    end
                end
            end
            if (inVld && inRdy1) q1.push_back(model(inOp, inInv, inCin, inCasa, inRs1, inRs2, inRs3));
            if (inVld && inRdy2) q2.push_back(model(inOp, inInv, inCin, inCasa, inRs1, inRs2, inRs3));
        end
    end

    // Holds one operation until the LAT=2 instance takes it; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic inv, input logic cin, input logic casa,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bit got = 1'b0;
        inOp = op; inInv = inv; inCin = cin; inCasa = casa;
        inRs1 = a; inRs2 = b; inRs3 = c;
        inVld = 1'b1;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge rclk);
            if (inRdy2) got = 1'b1;
        end
        if (!got) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL issue_timeout in_rdy=%b want 1", inRdy2);
        end
        @(posedge rclk);
        #1;
        inVld = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        nVectors++;
        if ({o1Vld, o1Data, o1Va, o1VaInv, o1Icc, o1Xcc} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_lat1 vld=%b data=%h va=%h icc=%b xcc=%b want all 0",
                     o1Vld, o1Data, o1Va, o1Icc, o1Xcc);
        end
        nVectors++;
        if ({o2Vld, o2Data, o2Va, o2VaInv, o2Icc, o2Xcc} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_lat2 vld=%b data=%h va=%h icc=%b xcc=%b want all 0",
                     o2Vld, o2Data, o2Va, o2Icc, o2Xcc);
        end
        nVectors++;
        if (inRdy1 !== 1'b1 || inRdy2 !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL reset_rdy in_rdy=%b/%b want 1/1", inRdy1, inRdy2);
        end
        rst_l = 1'b1;
        @(posedge rclk);
        #1;
    endtask

    task automatic test_add_carry();
        issue(OP_ADD, 1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0);
        nVectors++;
        if (o1Vld !== 1'b1 || o1Data !== 64'h1_0000_0000 || o1Icc !== 4'b0101 || o1Xcc !== 4'b0000) begin
            nMiscompares++;
            $display("[TB] FAIL add_carry_lat1 vld=%b data=%h icc=%b xcc=%b want 1 100000000 0101 0000",
                     o1Vld, o1Data, o1Icc, o1Xcc);
        end
        nVectors++;
        if (o2Vld !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL add_carry_lat2_early vld=%b want 0", o2Vld);
        end
        @(posedge rclk);
        #1;
        nVectors++;
        if (o2Vld !== 1'b1 || o2Data !== 64'h1_0000_0000 || o2Icc !== 4'b0101 || o2Xcc !== 4'b0000) begin
            nMiscompares++;
            $display("[TB] FAIL add_carry_lat2 vld=%b data=%h icc=%b xcc=%b want 1 100000000 0101 0000",
                     o2Vld, o2Data, o2Icc, o2Xcc);
        end
        nVectors++;
        if (o1Vld !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL bubble_lat1 vld=%b want 0", o1Vld);
        end
    endtask

    task automatic test_sub();
        issue(OP_SUB, 1'b0, 1'b1, 1'b0, 64'd5, 64'd7, 64'd0);
        nVectors++;
        if (o1Data !== 64'hFFFF_FFFF_FFFF_FFFE || o1Icc !== 4'b1001 || o1Xcc !== 4'b1001) begin
            nMiscompares++;
            $display("[TB] FAIL sub_borrow data=%h icc=%b xcc=%b want fffffffffffffffe 1001 1001",
                     o1Data, o1Icc, o1Xcc);
        end
    endtask

    task automatic test_overflow_va();
        issue(OP_ADD, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        nVectors++;
        if (o1Xcc !== 4'b1010 || o1Icc !== 4'b0101 || o1VaInv !== 1'b1 || o1Va !== 48'd0) begin
            nMiscompares++;
            $display("[TB] FAIL overflow_va xcc=%b icc=%b va_inv=%b va=%h want 1010 0101 1 0",
                     o1Xcc, o1Icc, o1VaInv, o1Va);
        end
        issue(OP_ADD, 1'b0, 1'b0, 1'b1, 64'hFFFF_8000_0000_0000, 64'h0000_0000_0000_1234, 64'd0);
        nVectors++;
        if (o1VaInv !== 1'b0 || o1Va !== 48'h8000_0000_0000) begin
            nMiscompares++;
            $display("[TB] FAIL casa_va va_inv=%b va=%h want 0 800000000000", o1VaInv, o1Va);
        end
    endtask

    task automatic test_logic();
        issue(OP_AND, 1'b1, 1'b0, 1'b0, 64'hF0, 64'h30, 64'd0);
        nVectors++;
        if (o1Data !== 64'hC0 || o1Icc !== 4'b0000 || o1Xcc !== 4'b0000) begin
            nMiscompares++;
            $display("[TB] FAIL andn data=%h icc=%b xcc=%b want c0 0000 0000", o1Data, o1Icc, o1Xcc);
        end
        issue(OP_SETHI, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678, 64'd0);
        nVectors++;
        if (o1Data !== 64'h1234_5400 || o1Icc !== 4'b0000 || o1Xcc !== 4'b0000) begin
            nMiscompares++;
            $display("[TB] FAIL sethi data=%h icc=%b xcc=%b want 12345400 0000 0000", o1Data, o1Icc, o1Xcc);
        end
        issue(OP_OR, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
        nVectors++;
        if (o1Data !== 64'hFFFF_FFFF_FFFF_FFFF || o1Icc !== 4'b1000 || o1Xcc !== 4'b1000) begin
            nMiscompares++;
            $display("[TB] FAIL orn data=%h icc=%b xcc=%b want all-ones 1000 1000", o1Data, o1Icc, o1Xcc);
        end
        issue(OP_XOR, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        nVectors++;
        if (o1Data !== 64'd0 || o1Icc !== 4'b0100 || o1Xcc !== 4'b0100) begin
            nMiscompares++;
            $display("[TB] FAIL xor_zero data=%h icc=%b xcc=%b want 0 0100 0100", o1Data, o1Icc, o1Xcc);
        end
    endtask

    task automatic test_back_to_back();
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        fork
            begin
                issue(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd100, 64'd23, 64'd0);
                issue(OP_SUB, 1'b0, 1'b0, 1'b0, 64'd50, 64'd8, 64'd0);
                issue(OP_XOR, 1'b0, 1'b0, 1'b0, 64'hAA, 64'h0F, 64'd0);
            end
            begin
                @(posedge rclk);
                @(posedge rclk);
                #1;
                rdy2 = 1'b0;
                @(negedge rclk);
                nVectors++;
                if (inRdy2 !== 1'b0 || o2Vld !== 1'b1 || o2Data !== 64'd123) begin
                    nMiscompares++;
                    $display("[TB] FAIL stall_start in_rdy=%b vld=%b data=%h want 0 1 7b", inRdy2, o2Vld, o2Data);
                end
                for (int k = 0; k < 2; k++) begin
                    @(posedge rclk);
                    #1;
                    nVectors++;
                    if (inRdy2 !== 1'b0 || o2Vld !== 1'b1 || o2Data !== 64'd123 || o2Xcc !== 4'b0000) begin
                        nMiscompares++;
                        $display("[TB] FAIL stall_hold in_rdy=%b vld=%b data=%h xcc=%b want 0 1 7b 0000",
                                 inRdy2, o2Vld, o2Data, o2Xcc);
                    end
                end
                rdy2 = 1'b1;
            end
        join
        repeat (3) @(posedge rclk);
        #1;
    endtask

    function automatic logic [63:0] randVal();
        case ($urandom_range(0, 3))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return {32'd0, 32'($urandom_range(0, 16))};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        randDone = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge rclk);
                        #1;
                    end
                    issue(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                          randVal(), randVal(), randVal());
                end
                randDone = 1'b1;
            end
            begin
                for (int k = 0; k < 3000 && !randDone; k++) begin
                    @(posedge rclk);
                    #1;
                    rdy1 = ($urandom_range(0, 3) != 0);
                    rdy2 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        repeat (4) @(posedge rclk);
        #1;
    endtask

    task automatic test_reset_inflight();
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        issue(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0);
        issue(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd3, 64'd4, 64'd0);
        rst_l = 1'b0;
        @(posedge rclk);
        #1;
        nVectors++;
        if ({o1Vld, o1Data, o1Va, o1VaInv, o1Icc, o1Xcc, o2Vld, o2Data, o2Va, o2VaInv, o2Icc, o2Xcc} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_inflight vld=%b/%b data=%h/%h want 0/0 0/0", o1Vld, o2Vld, o1Data, o2Data);
        end
        rst_l = 1'b1;
        issue(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd10, 64'd20, 64'd0);
        nVectors++;
        if (o1Vld !== 1'b1 || o1Data !== 64'd30 || o2Vld !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL post_reset_lat1 vld=%b data=%h lat2_vld=%b want 1 1e 0", o1Vld, o1Data, o2Vld);
        end
        @(posedge rclk);
        #1;
        nVectors++;
        if (o2Vld !== 1'b1 || o2Data !== 64'd30) begin
            nMiscompares++;
            $display("[TB] FAIL post_reset_lat2 vld=%b data=%h want 1 1e", o2Vld, o2Data);
        end
        repeat (2) @(posedge rclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add_carry();
        test_sub();
        test_overflow_va();
        test_logic();
        repeat (3) @(posedge rclk);
        #1;
        test_back_to_back();
        test_random();
        test_reset_inflight();
        nVectors++;
        if (q1.size() != 0 || q2.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain pending=%0d/%0d want 0/0", q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
